// File: rtl/riscv_mon_pkg.sv
// Shared definitions for the retirement monitor: RV32I opcodes, default halt words,
// halt FSM states and the OUTPUT_PORT source decoder.
package riscv_mon_pkg;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Program-end sequence emitted by the lab runtime: li ra,12 ; ret
  localparam logic [31:0] HALT_WORD0 = 32'h00c00093;
  localparam logic [31:0] HALT_WORD1 = 32'h00008067;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HALTED
  } halt_state_t;

  typedef enum logic [1:0] {
    SEL_MEM,
    SEL_BR,
    SEL_WD,
    SEL_NONE
  } out_sel_t;

  function automatic out_sel_t decode_opcode(input logic [6:0] opc);
    out_sel_t sel;
    case (opc)
      OPC_STORE:  sel = SEL_MEM;
      OPC_BRANCH: sel = SEL_BR;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OPIMM, OPC_OP:
                  sel = SEL_WD;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/halt_detector.sv
// Three-state detector for the two-word program-end sequence; bubbles between the
// words leave the armed state untouched, and HALTED is terminal until reset.
module halt_detector
  import riscv_mon_pkg::*;
#(
  parameter logic [31:0] HALT_INST0 = HALT_WORD0,
  parameter logic [31:0] HALT_INST1 = HALT_WORD1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        valid,
  input  logic [31:0] inst,
  output logic        halted
);

  halt_state_t state;
  halt_state_t state_next;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order in which always blocks are evaluated.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is assigned before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (valid && inst == HALT_INST0) state_next = ARMED;
      end
      ARMED: begin
        if (valid) begin
          if (inst == HALT_INST1)      state_next = HALTED;
          else if (inst == HALT_INST0) state_next = ARMED;
          else                         state_next = IDLE;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  assign halted = (state == HALTED);

endmodule

// File: rtl/retire_monitor.sv
// Commit-side observer: counts retirements, latches a per-instruction result and
// flags the program end. Optional CYCLE_CNT output under RETIRE_MONITOR_CYCLE_CNT_EN.
module retire_monitor
  import riscv_mon_pkg::*;
#(
  parameter logic [31:0] HALT_INST0 = HALT_WORD0,
  parameter logic [31:0] HALT_INST1 = HALT_WORD1,
  parameter int          CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RET_VALID,
  input  logic [31:0]      RET_INST,
  input  logic [31:0]      RET_RF_WD,
  input  logic [31:0]      RET_MEM_ADDR,
  input  logic             RET_BR_TAKEN,
  output logic [CNT_W-1:0] NUM_INST,
  output logic [31:0]      OUTPUT_PORT,
  output logic             HALT,
  output logic             ILLEGAL
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
  ,
  output logic [31:0]      CYCLE_CNT
`endif
);

  logic     accept;
  out_sel_t out_sel;

  // Once halted the core may keep retiring; those retirements are ignored.
  assign accept  = RET_VALID && !HALT;
  assign out_sel = decode_opcode(RET_INST[6:0]);

  halt_detector #(
    .HALT_INST0 (HALT_INST0),
    .HALT_INST1 (HALT_INST1)
  ) u_halt_detector (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .valid  (RET_VALID),
    .inst   (RET_INST),
    .halted (HALT)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      NUM_INST    <= '0;
      OUTPUT_PORT <= '0;
      ILLEGAL     <= 1'b0;
    end else if (accept) begin
      if (NUM_INST != '1) NUM_INST <= NUM_INST + CNT_W'(1);
      unique case (out_sel)
        SEL_MEM: OUTPUT_PORT <= RET_MEM_ADDR;
        SEL_BR:  OUTPUT_PORT <= {31'b0, RET_BR_TAKEN};
        SEL_WD:  OUTPUT_PORT <= RET_RF_WD;
        default: ILLEGAL     <= 1'b1;
      endcase
    end
  end

`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
  // HALT is still low at the edge where it rises, so the halting cycle is counted.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      CYCLE_CNT <= '0;
    end else if (!HALT && CYCLE_CNT != '1) begin
      CYCLE_CNT <= CYCLE_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// Randomized self-checking bench for retire_monitor; a second instance with CNT_W=4
// exercises counter saturation. CYCLE_CNT is checked when RETIRE_MONITOR_CYCLE_CNT_EN is set.
module tb_retire_monitor;

  localparam logic [31:0] H0 = 32'h00c00093;
  localparam logic [31:0] H1 = 32'h00008067;
  localparam logic [31:0] SW_I   = 32'h00112623;
  localparam logic [31:0] BGE_I  = 32'h0020d463;
  localparam logic [31:0] BLT_I  = 32'h0020c463;
  localparam logic [31:0] ADDI_I = 32'h00400013;
  localparam logic [31:0] ADD_I  = 32'h002081b3;
  localparam logic [31:0] ECALL_I = 32'h00000073;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        RET_VALID = 1'b0;
  logic [31:0] RET_INST = '0;
  logic [31:0] RET_RF_WD = '0;
  logic [31:0] RET_MEM_ADDR = '0;
  logic        RET_BR_TAKEN = 1'b0;

  logic [31:0] num_inst, output_port;
  logic        halt, illegal;
  logic [3:0]  num_inst4;
  logic [31:0] output_port4;
  logic        halt4, illegal4;
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
  logic [31:0] cycle_cnt, cycle_cnt4;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_cnt, m_out, m_last, m_cyc;
  int          m_cnt4;
  bit          m_halt, m_ill;

  always #5 CLK = ~CLK;

  retire_monitor dut (
    .CLK (CLK), .RSTn (RSTn), .RET_VALID (RET_VALID), .RET_INST (RET_INST),
    .RET_RF_WD (RET_RF_WD), .RET_MEM_ADDR (RET_MEM_ADDR), .RET_BR_TAKEN (RET_BR_TAKEN),
    .NUM_INST (num_inst), .OUTPUT_PORT (output_port), .HALT (halt), .ILLEGAL (illegal)
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
    , .CYCLE_CNT (cycle_cnt)
`endif
  );

  retire_monitor #(.CNT_W (4)) dut4 (
    .CLK (CLK), .RSTn (RSTn), .RET_VALID (RET_VALID), .RET_INST (RET_INST),
    .RET_RF_WD (RET_RF_WD), .RET_MEM_ADDR (RET_MEM_ADDR), .RET_BR_TAKEN (RET_BR_TAKEN),
    .NUM_INST (num_inst4), .OUTPUT_PORT (output_port4), .HALT (halt4), .ILLEGAL (illegal4)
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
    , .CYCLE_CNT (cycle_cnt4)
`endif
  );

  task automatic model_reset();
    m_cnt = '0; m_out = '0; m_last = '0; m_cyc = '0;
    m_cnt4 = 0; m_halt = 0; m_ill = 0;
  endtask

  // Reset pulse that never straddles a rising edge.
  task automatic do_reset();
    RSTn = 1'b0;
    RET_VALID = 1'b0;
    model_reset();
    #3;
    RSTn = 1'b1;
  endtask

  // Drives one cycle, advances the model from the pre-edge state, samples 1ns after the edge.
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] wd,
                      input logic [31:0] addr, input bit br);
    RET_VALID = v; RET_INST = inst; RET_RF_WD = wd; RET_MEM_ADDR = addr; RET_BR_TAKEN = br;
    if (!m_halt && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    if (v && !m_halt) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      case (inst[6:0])
        7'b0100011: m_out = addr;
        7'b1100011: m_out = {31'b0, br};
        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
        7'b0000011, 7'b0010011, 7'b0110011: m_out = wd;
        default: m_ill = 1;
      endcase
      // Program end: HALT_INST1 accepted right after an accepted HALT_INST0.
      if (inst == H1 && m_last == H0) m_halt = 1;
      m_last = inst;
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 11);
    case (k)
      0: opc = 7'b0100011;  1: opc = 7'b1100011;  2: opc = 7'b0110111;
      3: opc = 7'b0010111;  4: opc = 7'b1101111;  5: opc = 7'b1100111;
      6: opc = 7'b0000011;  7: opc = 7'b0010011;  8: opc = 7'b0110011;
      default: opc = 7'b1110011;
    endcase
    if (k == 10) return H0;
    if (k == 11) return H1;
    return {r[31:7], opc};
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (num_inst !== 32'd0)    begin bad++; $display("FAIL reset_num got=%0h exp=0", num_inst); end
    total++; if (output_port !== 32'd0) begin bad++; $display("FAIL reset_out got=%0h exp=0", output_port); end
    total++; if (halt !== 1'b0)         begin bad++; $display("FAIL reset_halt got=%0b exp=0", halt); end
    total++; if (illegal !== 1'b0)      begin bad++; $display("FAIL reset_ill got=%0b exp=0", illegal); end
    step(1, ADD_I, 32'h1234, 0, 0);
    step(1, ECALL_I, 0, 0, 0);
    step(1, H0, 32'h0c, 0, 0);
    // Asynchronous clear between edges
    RSTn = 1'b0;
    #2;
    total++; if (num_inst !== 32'd0 || output_port !== 32'd0 || illegal !== 1'b0 || halt !== 1'b0) begin
      bad++; $display("FAIL async_clear got num=%0h out=%0h ill=%0b halt=%0b exp all 0",
                      num_inst, output_port, illegal, halt);
    end
    model_reset();
    RSTn = 1'b1;
    step(1, SW_I, 32'hdead, 32'h0eec, 0);
    total++; if (num_inst !== m_cnt)    begin bad++; $display("FAIL store_num got=%0h exp=%0h", num_inst, m_cnt); end
    total++; if (output_port !== m_out) begin bad++; $display("FAIL store_out got=%0h exp=%0h", output_port, m_out); end
  endtask

  task automatic test_branch_bubbles();
    logic [31:0] base;
    base = m_cnt;
    step(1, BGE_I, 32'h55, 32'h66, 1);
    total++; if (output_port !== 32'd1) begin bad++; $display("FAIL bge_taken got=%0h exp=1", output_port); end
    for (int i = 0; i < 3; i++) begin
      step(0, BLT_I, 32'h77, 32'h88, 0);
      total++; if (output_port !== m_out || num_inst !== m_cnt) begin
        bad++; $display("FAIL bubble got out=%0h num=%0h exp out=%0h num=%0h", output_port, num_inst, m_out, m_cnt);
      end
    end
    step(1, BLT_I, 32'h99, 32'haa, 0);
    total++; if (output_port !== 32'd0) begin bad++; $display("FAIL blt_not_taken got=%0h exp=0", output_port); end
    total++; if (num_inst !== base + 2) begin bad++; $display("FAIL branch_count got=%0h exp=%0h", num_inst, base + 2); end
  endtask

  task automatic test_alu_illegal();
    step(1, ADDI_I, 32'h4, 32'h100, 1);
    total++; if (output_port !== 32'h4) begin bad++; $display("FAIL addi_x0 got=%0h exp=4", output_port); end
    total++; if (illegal !== 1'b0)      begin bad++; $display("FAIL ill_early got=%0b exp=0", illegal); end
    step(1, ECALL_I, 32'h9, 32'h200, 1);
    total++; if (output_port !== 32'h4) begin bad++; $display("FAIL ill_hold got=%0h exp=4", output_port); end
    total++; if (illegal !== 1'b1)      begin bad++; $display("FAIL ill_set got=%0b exp=1", illegal); end
    total++; if (num_inst !== m_cnt)    begin bad++; $display("FAIL ill_count got=%0h exp=%0h", num_inst, m_cnt); end
  endtask

  task automatic test_halt_gap();
    do_reset();
    step(1, H0, 32'h0c, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_early got=%0b exp=0", halt); end
    step(1, H1, 32'h0abc, 0, 0);
    total++; if (halt !== 1'b1)         begin bad++; $display("FAIL halt_gap got=%0b exp=1", halt); end
    total++; if (num_inst !== 32'd2)    begin bad++; $display("FAIL halt_num got=%0h exp=2", num_inst); end
    total++; if (output_port !== 32'h0abc) begin bad++; $display("FAIL halt_out got=%0h exp=abc", output_port); end
    step(1, ADD_I, 32'h0f00, 0, 0);
    total++; if (num_inst !== 32'd2 || output_port !== 32'h0abc || halt !== 1'b1 || illegal !== 1'b0) begin
      bad++; $display("FAIL post_halt got num=%0h out=%0h halt=%0b ill=%0b", num_inst, output_port, halt, illegal);
    end
  endtask

  task automatic test_broken_sequence();
    do_reset();
    step(1, H0, 32'h0c, 0, 0);
    step(1, ADD_I, 32'h3, 0, 0);
    step(1, H1, 32'h4, 0, 0);
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL broken_seq got=%0b exp=0", halt); end
    step(1, H0, 32'h0c, 0, 0);
    step(1, H0, 32'h0c, 0, 0);
    step(1, H1, 32'h8, 0, 0);
    total++; if (halt !== 1'b1)      begin bad++; $display("FAIL double_h0 got=%0b exp=1", halt); end
    total++; if (num_inst !== m_cnt) begin bad++; $display("FAIL double_h0_num got=%0h exp=%0h", num_inst, m_cnt); end
    // Reset between the two words must forget the armed state.
    do_reset();
    step(1, H0, 32'h0c, 0, 0);
    do_reset();
    step(1, H1, 32'h8, 0, 0);
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_disarm got=%0b exp=0", halt); end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 3) != 0), rand_inst(), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
        total++;
        if (num_inst !== m_cnt || output_port !== m_out || halt !== m_halt || illegal !== m_ill) begin
          bad++;
          $display("FAIL random r%0d c%0d got num=%0h out=%0h halt=%0b ill=%0b exp num=%0h out=%0h halt=%0b ill=%0b",
                   round, i, num_inst, output_port, halt, illegal, m_cnt, m_out, m_halt, m_ill);
        end
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
        total++; if (cycle_cnt !== m_cyc) begin bad++; $display("FAIL random_cyc got=%0h exp=%0h", cycle_cnt, m_cyc); end
`endif
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, ADD_I, $urandom(), 0, 0);
      total++;
      if (num_inst4 !== 4'(m_cnt4) || num_inst !== m_cnt || output_port4 !== m_out) begin
        bad++; $display("FAIL saturate i=%0d got n4=%0h n=%0h o4=%0h exp n4=%0h n=%0h o4=%0h",
                        i, num_inst4, num_inst, output_port4, m_cnt4, m_cnt, m_out);
      end
    end
    total++; if (num_inst4 !== 4'hF) begin bad++; $display("FAIL saturate_final got=%0h exp=f", num_inst4); end
    step(1, H0, 32'h0c, 0, 0);
    step(1, H1, 32'h1, 0, 0);
    total++; if (halt4 !== 1'b1 || illegal4 !== 1'b0) begin
      bad++; $display("FAIL sat_halt got halt4=%0b ill4=%0b exp 1/0", halt4, illegal4);
    end
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
    total++; if (cycle_cnt !== 32'd22) begin bad++; $display("FAIL cyc_halt_edge got=%0d exp=22", cycle_cnt); end
    for (int i = 0; i < 6; i++) begin
      step(i[0], ADD_I, 32'h5, 0, 0);
      total++; if (cycle_cnt !== m_cyc || cycle_cnt4 !== m_cyc) begin
        bad++; $display("FAIL cyc_freeze got=%0d/%0d exp=%0d", cycle_cnt, cycle_cnt4, m_cyc);
      end
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch_bubbles();
    test_alu_illegal();
    test_halt_gap();
    test_broken_sequence();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
